// File: rtl/nn_argmax_stream.sv
// -----------------------------------------------------------------------------
// nn_argmax_stream
//
// Purpose:
//   Sequential classifier back end for the 2-layer softmax network. Softmax
//   scores arrive one signed fixed-point word per cycle on a valid/ready
//   stream. For every OUT_SIZE-element vector the block emits the index of the
//   largest score (ties keep the lower index) together with the winning score
//   and the vector number. After BATCH results have been handed off the block
//   parks in DONE with batch_done held high until clear or reset.
//
// Optional feature (compile-time macro NN_ARGMAX_ERRCHK_EN):
//   defined   : err is a sticky flag set by any accepted negative score, or by
//               out_ready pulsed while no result is pending in DONE.
//   undefined : err is tied low and no checker logic exists.
//
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   clear       in   1       synchronous restart (counters 0, state ACCUM)
//   in_valid    in   1       score word valid
//   in_ready    out  1       block accepts a score word (high only in ACCUM)
//   in_data     in   WIDTH   signed score, Q(WIDTH-FRAC).FRAC
//   out_valid   out  1       result valid
//   out_ready   in   1       downstream accepts result
//   out_idx     out  IDX_W   argmax class index
//   out_max     out  WIDTH   winning score
//   out_batch   out  BAT_W   0-based vector number of this result
//   batch_done  out  1       all BATCH results handed off (held level)
//   err         out  1       sticky input-check error (see macro above)
// -----------------------------------------------------------------------------
module nn_argmax_stream #(
  parameter  int WIDTH    = 18,
  parameter  int FRAC     = 8,
  parameter  int OUT_SIZE = 3,
  parameter  int BATCH    = 300,
  localparam int IDX_W    = $clog2(OUT_SIZE),
  localparam int BAT_W    = $clog2(BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_max,
  output logic [BAT_W-1:0] out_batch,
  output logic             batch_done,
  output logic             err
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  generate
    if (OUT_SIZE < 2) begin : g_bad_out_size
      $error("nn_argmax_stream: OUT_SIZE must be >= 2");
    end
    if (BATCH < 1) begin : g_bad_batch
      $error("nn_argmax_stream: BATCH must be >= 1");
    end
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
      $error("nn_argmax_stream: FRAC must lie in [0, WIDTH)");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(OUT_SIZE - 1);
  localparam logic [BAT_W-1:0] LAST_VEC  = BAT_W'(BATCH - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q,      state_d;
  logic        [IDX_W-1:0]   elem_cnt_q,   elem_cnt_d;
  logic        [BAT_W-1:0]   bat_cnt_q,    bat_cnt_d;
  logic signed [WIDTH-1:0]   run_max_q,    run_max_d;
  logic        [IDX_W-1:0]   run_idx_q,    run_idx_d;
  logic                      out_valid_q,  out_valid_d;
  logic        [IDX_W-1:0]   out_idx_q,    out_idx_d;
  logic        [WIDTH-1:0]   out_max_q,    out_max_d;
  logic        [BAT_W-1:0]   out_batch_q,  out_batch_d;
  logic                      batch_done_q, batch_done_d;

  // in_ready depends on registered state only, so there is no combinational
  // path from in_valid to in_ready.
  logic in_fire;
  assign in_ready = (state_q == ST_ACCUM);
  assign in_fire  = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Running argmax candidate for the current beat.
  // Element 0 always seeds the running maximum. Later elements replace it only
  // on a strictly greater signed value, so ties keep the lower index.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] cand_max;
  logic        [IDX_W-1:0] cand_idx;

  always_comb begin
    cand_max = run_max_q;
    cand_idx = run_idx_q;
    if ((elem_cnt_q == '0) || ($signed(in_data) > run_max_q)) begin
      cand_max = $signed(in_data);
      cand_idx = elem_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    elem_cnt_d   = elem_cnt_q;
    bat_cnt_d    = bat_cnt_q;
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_max_d    = out_max_q;
    out_batch_d  = out_batch_q;
    batch_done_d = batch_done_q;

    if (clear) begin
      // Any beat or handoff presented alongside clear is dropped.
      state_d      = ST_ACCUM;
      elem_cnt_d   = '0;
      bat_cnt_d    = '0;
      out_valid_d  = 1'b0;
      batch_done_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (in_fire) begin
            run_max_d = cand_max;
            run_idx_d = cand_idx;
            if (elem_cnt_q == LAST_ELEM) begin
              // Final compare goes straight to the output registers so the
              // result is valid on the cycle after the last beat.
              out_idx_d   = cand_idx;
              out_max_d   = cand_max;
              out_batch_d = bat_cnt_q;
              out_valid_d = 1'b1;
              elem_cnt_d  = '0;
              state_d     = ST_EMIT;
            end else begin
              elem_cnt_d = elem_cnt_q + IDX_W'(1);
            end
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            bat_cnt_d   = bat_cnt_q + BAT_W'(1);
            if (bat_cnt_q == LAST_VEC) begin
              batch_done_d = 1'b1;
              state_d      = ST_DONE;
            end else begin
              state_d = ST_ACCUM;
            end
          end
        end

        ST_DONE: begin
          out_valid_d  = 1'b0;
          batch_done_d = 1'b1;
        end

        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      elem_cnt_q   <= '0;
      bat_cnt_q    <= '0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_max_q    <= '0;
      out_batch_q  <= '0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_cnt_q   <= elem_cnt_d;
      bat_cnt_q    <= bat_cnt_d;
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_max_q    <= out_max_d;
      out_batch_q  <= out_batch_d;
      batch_done_q <= batch_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_max    = out_max_q;
  assign out_batch  = out_batch_q;
  assign batch_done = batch_done_q;

  // ---------------------------------------------------------------------------
  // Optional input checker. Observes the stream only; the datapath ignores it.
  // ---------------------------------------------------------------------------
`ifdef NN_ARGMAX_ERRCHK_EN
  logic err_q, err_d;
  logic neg_beat;
  logic stray_ready;

  // Softmax outputs are never negative, so a set sign bit means corruption.
  assign neg_beat    = in_fire && in_data[WIDTH-1];
  // A ready pulse with nothing to take after the batch indicates a
  // downstream that lost track of the result count.
  assign stray_ready = (state_q == ST_DONE) && out_ready && !out_valid_q;

  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (neg_beat || stray_ready) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
